// File: rtl/mux8_pkg.sv
// mux8_pkg: default width and reset word shared by byte-wide datapath muxes
package mux8_pkg;
  localparam int MUX_WIDTH = 8;
  localparam logic [MUX_WIDTH-1:0] MUX_RST_VAL = '0;
endpackage

// File: rtl/mux8_mux2_comb.sv
// mux2_comb: pure combinational WIDTH-bit 2:1 select; an unknown s merges a and b bitwise
module mux2_comb #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic [WIDTH-1:0] y
);
  assign y = s ? b : a;
endmodule

// File: rtl/mux8.sv
// mux8: 2:1 word multiplexer with optional output register, valid tracking and async reset forcing
module mux8
  import mux8_pkg::*;
#(
  parameter int               WIDTH   = MUX_WIDTH,
  parameter bit               REG_OUT = 1'b1,
  parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(MUX_RST_VAL)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  input  logic             in_valid,
  output logic [WIDTH-1:0] y,
  output logic             out_valid
);
  logic [WIDTH-1:0] sel;
  mux2_comb #(.WIDTH(WIDTH)) u_sel (.a(a), .b(b), .s(s), .y(sel));
  if (REG_OUT) begin : g_reg
    logic [WIDTH-1:0] y_q;
    logic             v_q;
    // capture the selected word on valid cycles; hold it otherwise while valid drops
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        y_q <= RST_VAL;
        v_q <= 1'b0;
      end else begin
        if (in_valid) y_q <= sel;
        v_q <= in_valid;
      end
    end
    assign y         = y_q;
    assign out_valid = v_q;
  end else begin : g_comb
    assign y         = rst ? RST_VAL : sel;
    assign out_valid = !rst && in_valid;
  end
endmodule

// File: tb/tb_mux8.sv
// tb_mux8: directed checks of registered and combinational mux8 builds
module tb_mux8;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] a = '0, b = '0;
  logic       s = 1'b0, in_valid = 1'b0;
  logic [7:0] y_r, y_c;
  logic       ov_r, ov_c;
  int compares = 0;
  int fails = 0;
  always #5 clk = ~clk;
  mux8 #(.REG_OUT(1'b1)) u_reg (.clk(clk), .rst(rst), .a(a), .b(b), .s(s),
                                .in_valid(in_valid), .y(y_r), .out_valid(ov_r));
  mux8 #(.REG_OUT(1'b0)) u_cmb (.clk(clk), .rst(rst), .a(a), .b(b), .s(s),
                                .in_valid(in_valid), .y(y_c), .out_valid(ov_c));
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    compares++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #2;
    chk("rst_y", y_r, 8'h00);
    chk("rst_ov", {7'b0, ov_r}, 8'h00);
    chk("rst_y_comb", y_c, 8'h00);
    chk("rst_ov_comb", {7'b0, ov_c}, 8'h00);
    @(negedge clk); rst = 1'b0;
    edge_wait();
    chk("post_rst_y", y_r, 8'h00);
    chk("post_rst_ov", {7'b0, ov_r}, 8'h00);
    @(negedge clk); a = 8'b11110000; b = 8'b00001111; s = 1'b0; in_valid = 1'b1;
    #1 chk("latency_pre", y_r, 8'h00);
    edge_wait();
    chk("sel_a", y_r, 8'b11110000);
    chk("sel_a_ov", {7'b0, ov_r}, 8'h01);
    @(negedge clk); s = 1'b1;
    edge_wait();
    chk("sel_b", y_r, 8'b00001111);
    @(negedge clk); a = 8'b10000000; b = 8'b00000001;
    edge_wait();
    chk("new_b", y_r, 8'b00000001);
    @(negedge clk); s = 1'b0;
    edge_wait();
    chk("new_a", y_r, 8'b10000000);
    @(negedge clk); in_valid = 1'b0; a = 8'h55; b = 8'hAA; s = 1'b1;
    edge_wait();
    chk("hold_y", y_r, 8'b10000000);
    chk("hold_ov", {7'b0, ov_r}, 8'h00);
    @(negedge clk); s = 1'b0;
    edge_wait();
    chk("hold_y2", y_r, 8'b10000000);
    @(negedge clk); in_valid = 1'b1;
    edge_wait();
    chk("resume_a", y_r, 8'h55);
    chk("resume_ov", {7'b0, ov_r}, 8'h01);
    @(negedge clk); s = 1'b1;
    edge_wait();
    chk("resume_b", y_r, 8'hAA);
    @(negedge clk); a = 8'hA5; s = 1'b0;
    edge_wait();
    chk("pre_rst_y", y_r, 8'hA5);
    #2 rst = 1'b1; a = 8'h33;
    #1 chk("async_rst_y", y_r, 8'h00);
    chk("async_rst_ov", {7'b0, ov_r}, 8'h00);
    chk("async_rst_y_comb", y_c, 8'h00);
    chk("async_rst_ov_comb", {7'b0, ov_c}, 8'h00);
    edge_wait();
    chk("in_rst_y", y_r, 8'h00);
    @(negedge clk); rst = 1'b0; in_valid = 1'b0;
    edge_wait();
    chk("release_y", y_r, 8'h00);
    chk("release_ov", {7'b0, ov_r}, 8'h00);
    @(negedge clk); in_valid = 1'b1;
    edge_wait();
    chk("first_cap", y_r, 8'h33);
    @(negedge clk); a = 8'h3C; b = 8'h3C; s = 1'bx;
    edge_wait();
    chk("x_sel_agree", y_r, 8'h3C);
    chk("x_sel_agree_comb", y_c, 8'h3C);
    @(negedge clk); a = 8'h12; b = 8'h34; s = 1'b0;
    #1 chk("comb_a", y_c, 8'h12);
    chk("comb_ov", {7'b0, ov_c}, 8'h01);
    #1 s = 1'b1;
    #1 chk("comb_b", y_c, 8'h34);
    #1 s = 1'b0;
    #1 chk("comb_a2", y_c, 8'h12);
    #1 in_valid = 1'b0;
    #1 chk("comb_ov_low", {7'b0, ov_c}, 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end
endmodule
